// File: rtl/elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Single-car elevator controller using a SCAN policy. The car keeps travelling
// in its current direction while requests remain ahead of it. It reverses only
// when the side ahead is empty and requests remain behind it.
//
// A single timer is shared by the MOVE and DOOR states. It counts only while
// enable is high. It times the floor-to-floor travel in MOVE and the dwell
// period in DOOR.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset
//   enable      1 = timer advances and the FSM may change state; 0 = frozen
//   call_req    one request bit per floor, latched into pending
//   door_hold   level; while the door is open, keeps restarting the dwell
//   door_close  pulse; ends the dwell early unless door_hold is high
//   cur_floor   current floor index
//   dir_up      1 = current or last travel direction is up
//   moving      high while in MOVE
//   door_open   high while in DOOR
//   pending     registered outstanding-request vector
// -----------------------------------------------------------------------------
module elevator_scan_ctrl #(
    parameter int FLOORS     = 4,
    parameter int FW         = 2,
    parameter int TRAVEL_CYC = 50_000_000,
    parameter int DOOR_CYC   = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [FLOORS-1:0] call_req,
    input  logic              door_hold,
    input  logic              door_close,
    output logic [FW-1:0]     cur_floor,
    output logic              dir_up,
    output logic              moving,
    output logic              door_open,
    output logic [FLOORS-1:0] pending
);

    // The timer must hold the larger of the two terminal counts without wrapping.
    localparam int            MAX_CYC     = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int            TW          = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_e;

    // Outcome of the scan rule when the car is ready to leave a floor.
    typedef enum logic [1:0] {
        D_AHEAD,
        D_REVERSE,
        D_STOP
    } decide_e;

    state_e            state_q,     state_d;
    logic [FW-1:0]     cur_floor_q, cur_floor_d;
    logic              dir_up_q,    dir_up_d;
    logic              moving_q,    moving_d;
    logic              door_open_q, door_open_d;
    logic [FLOORS-1:0] pending_q,   pending_d;
    logic [TW-1:0]     timer_q,     timer_d;

    logic [FW-1:0]     next_floor;
    logic [FW-1:0]     leave_floor;
    logic              leave_req;
    logic [FLOORS-1:0] req_mask;
    logic [FLOORS-1:0] clr_mask;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i > int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i < int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    // Ahead/behind are relative to the travel direction. Because a move is
    // only started toward a non-empty side, the car can never step past
    // floor 0 or floor FLOORS-1.
    function automatic decide_e scan_decide(input logic [FLOORS-1:0] p,
                                            input logic [FW-1:0]     f,
                                            input logic              up);
        logic ahead;
        logic behind;
        ahead  = up ? any_above(p, f) : any_below(p, f);
        behind = up ? any_below(p, f) : any_above(p, f);
        if (ahead)  return D_AHEAD;
        if (behind) return D_REVERSE;
        return D_STOP;
    endfunction

    // NOTE: every signal assigned in this block receives a default value first.
    // A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        next_floor  = cur_floor_q;
        leave_req   = 1'b0;
        leave_floor = cur_floor_q;
        clr_mask    = '0;

        // A call for the floor the door is already open at is absorbed by the
        // dwell restart below. It is not recorded as a new request.
        req_mask = call_req;
        if (state_q == S_DOOR) req_mask[cur_floor_q] = 1'b0;

        if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pending_q[cur_floor_q]) begin
                        state_d               = S_DOOR;
                        timer_d               = '0;
                        clr_mask[cur_floor_q] = 1'b1;
                    end else if (|pending_q) begin
                        leave_req = 1'b1;
                    end
                end

                S_MOVE: begin
                    if (timer_q == TRAVEL_LAST) begin
                        timer_d     = '0;
                        next_floor  = dir_up_q ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
                        cur_floor_d = next_floor;
                        if (pending_q[next_floor]) begin
                            state_d              = S_DOOR;
                            clr_mask[next_floor] = 1'b1;
                        end else begin
                            leave_req   = 1'b1;
                            leave_floor = next_floor;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                S_DOOR: begin
                    // door_hold overrides door_close. A call at this floor
                    // restarts the dwell unless a close request is present.
                    if (door_hold) begin
                        timer_d = '0;
                    end else if (door_close) begin
                        timer_d   = '0;
                        leave_req = 1'b1;
                    end else if (call_req[cur_floor_q]) begin
                        timer_d = '0;
                    end else if (timer_q == DOOR_LAST) begin
                        timer_d   = '0;
                        leave_req = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end

        if (leave_req) begin
            unique case (scan_decide(pending_q, leave_floor, dir_up_q))
                D_AHEAD: begin
                    state_d = S_MOVE;
                end
                D_REVERSE: begin
                    state_d  = S_MOVE;
                    dir_up_d = ~dir_up_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Request latching continues even while enable is low.
        pending_d   = (pending_q & ~clr_mask) | req_mask;
        moving_d    = (state_d == S_MOVE);
        door_open_d = (state_d == S_DOOR);
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            pending_q   <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
        end
    end

    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//
// Testbench for elevator_scan_ctrl with FLOORS=4, TRAVEL_CYC=4, DOOR_CYC=3.
// The directed scenarios compare the outputs against hand-derived constants.
// The random scenario compares every output in every cycle against a
// behavioural model of the car. The model tracks an integer floor, a request
// set and a countdown of the cycles left in the current activity.
// -----------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

    localparam int FLOORS     = 4;
    localparam int FW         = 2;
    localparam int TRAVEL_CYC = 4;
    localparam int DOOR_CYC   = 3;
    localparam int WAIT_MAX   = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [FLOORS-1:0] call_req;
    logic              door_hold;
    logic              door_close;
    logic [FW-1:0]     cur_floor;
    logic              dir_up;
    logic              moving;
    logic              door_open;
    logic [FLOORS-1:0] pending;

    int n_vec = 0;
    int n_err = 0;

    elevator_scan_ctrl #(
        .FLOORS    (FLOORS),
        .FW        (FW),
        .TRAVEL_CYC(TRAVEL_CYC),
        .DOOR_CYC  (DOOR_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .call_req  (call_req),
        .door_hold (door_hold),
        .door_close(door_close),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef enum {M_REST, M_TRAVEL, M_DWELL} mmode_e;
    mmode_e            m_mode  = M_REST;
    int                m_floor = 0;
    bit                m_up    = 1'b1;
    bit [FLOORS-1:0]   m_req   = '0;
    int                m_left  = 0;

    function automatic int requests_toward(bit [FLOORS-1:0] r, int f, bit up);
        int n = 0;
        for (int i = 0; i < FLOORS; i++)
            if (r[i] && (up ? (i > f) : (i < f))) n++;
        return n;
    endfunction

    function automatic void open_door();
        m_mode         = M_DWELL;
        m_left         = DOOR_CYC;
        m_req[m_floor] = 1'b0;
    endfunction

    function automatic void depart_or_rest();
        if (requests_toward(m_req, m_floor, m_up) > 0) begin
            m_mode = M_TRAVEL;
            m_left = TRAVEL_CYC;
        end else if (requests_toward(m_req, m_floor, !m_up) > 0) begin
            m_up   = !m_up;
            m_mode = M_TRAVEL;
            m_left = TRAVEL_CYC;
        end else begin
            m_mode = M_REST;
        end
    endfunction

    task automatic model_step();
        bit [FLOORS-1:0] incoming;
        if (reset) begin
            m_mode  = M_REST;
            m_floor = 0;
            m_up    = 1'b1;
            m_req   = '0;
            m_left  = 0;
            return;
        end
        incoming = call_req;
        if (m_mode == M_DWELL) incoming[m_floor] = 1'b0;
        if (enable) begin
            case (m_mode)
                M_REST: begin
                    if (m_req[m_floor]) open_door();
                    else if (m_req != 0) depart_or_rest();
                end
                M_TRAVEL: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor += m_up ? 1 : -1;
                        if (m_req[m_floor]) open_door();
                        else depart_or_rest();
                    end
                end
                M_DWELL: begin
                    if (door_hold) m_left = DOOR_CYC;
                    else if (door_close) depart_or_rest();
                    else if (call_req[m_floor]) m_left = DOOR_CYC;
                    else begin
                        m_left--;
                        if (m_left == 0) depart_or_rest();
                    end
                end
                default: ;
            endcase
        end
        m_req |= incoming;
    endtask

    // ---------------- stimulus helpers (no comparisons) ----------------
    // One clock edge. The model sees the same inputs as the DUT. The outputs
    // are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        enable     = 1'b1;
        call_req   = '0;
        door_hold  = 1'b0;
        door_close = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_call(input logic [FLOORS-1:0] bits);
        call_req = bits;
        tick();
        call_req = '0;
    endtask

    task automatic wait_door(input logic want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (door_open === want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_floor(input logic [FW-1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (cur_floor === want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset    = 1'b1;
        call_req = 4'b1111;
        tick();
        tick();
        n_vec++; if (cur_floor !== 2'd0) begin n_err++; $display("FAIL reset_cur_floor: got %0d want 0", cur_floor); end
        n_vec++; if (dir_up !== 1'b1)    begin n_err++; $display("FAIL reset_dir_up: got %b want 1", dir_up); end
        n_vec++; if (moving !== 1'b0)    begin n_err++; $display("FAIL reset_moving: got %b want 0", moving); end
        n_vec++; if (door_open !== 1'b0) begin n_err++; $display("FAIL reset_door_open: got %b want 0", door_open); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending: got %b want 0000", pending); end
        idle_inputs();
        tick();
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_release_pending: got %b want 0000", pending); end
    endtask

    task automatic test_single_call();
        do_reset();
        pulse_call(4'b0100);
        n_vec++; if (pending !== 4'b0100) begin n_err++; $display("FAIL call_latch: got %b want 0100", pending); end
        n_vec++; if (moving !== 1'b0)     begin n_err++; $display("FAIL call_decide_latency: moving got %b want 0", moving); end
        tick();
        n_vec++; if (moving !== 1'b1)     begin n_err++; $display("FAIL call_start_move: moving got %b want 1", moving); end
        repeat (4) tick();
        n_vec++; if (cur_floor !== 2'd1)  begin n_err++; $display("FAIL call_floor1: got %0d want 1", cur_floor); end
        repeat (4) tick();
        n_vec++; if (cur_floor !== 2'd2 || door_open !== 1'b1 || pending !== 4'b0000 || moving !== 1'b0) begin
            n_err++;
            $display("FAIL call_arrive2: floor %0d door %b pending %b moving %b, want 2 1 0000 0",
                     cur_floor, door_open, pending, moving);
        end
        repeat (2) tick();
        n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL call_dwell: door_open got %b want 1", door_open); end
        tick();
        n_vec++; if (door_open !== 1'b0 || moving !== 1'b0) begin
            n_err++; $display("FAIL call_idle: door %b moving %b, want 0 0", door_open, moving);
        end
    endtask

    task automatic test_sweep();
        bit ok;
        do_reset();
        pulse_call(4'b1000);
        wait_floor(2'd1, ok);
        n_vec++; if (!ok || moving !== 1'b1 || dir_up !== 1'b1) begin
            n_err++; $display("FAIL sweep_at1: reached %b moving %b dir %b, want 1 1 1", ok, moving, dir_up);
        end
        pulse_call(4'b0001);
        n_vec++; if (pending !== 4'b1001) begin n_err++; $display("FAIL sweep_pending: got %b want 1001", pending); end
        wait_door(1'b1, ok);
        n_vec++; if (!ok || cur_floor !== 2'd3) begin
            n_err++; $display("FAIL sweep_first_stop: reached %b floor %0d want floor 3", ok, cur_floor);
        end
        wait_door(1'b0, ok);
        n_vec++; if (!ok || moving !== 1'b1 || dir_up !== 1'b0) begin
            n_err++; $display("FAIL sweep_reverse: reached %b moving %b dir %b, want 1 1 0", ok, moving, dir_up);
        end
        wait_door(1'b1, ok);
        n_vec++; if (!ok || cur_floor !== 2'd0 || pending !== 4'b0000) begin
            n_err++; $display("FAIL sweep_second_stop: reached %b floor %0d pending %b, want floor 0 pending 0000",
                              ok, cur_floor, pending);
        end
        wait_door(1'b0, ok);
        n_vec++; if (!ok || moving !== 1'b0) begin
            n_err++; $display("FAIL sweep_idle: reached %b moving %b want 0", ok, moving);
        end
    endtask

    task automatic test_door_hold();
        bit ok;
        do_reset();
        pulse_call(4'b0100);
        wait_door(1'b1, ok);
        n_vec++; if (!ok || cur_floor !== 2'd2) begin
            n_err++; $display("FAIL hold_open_at2: reached %b floor %0d want 2", ok, cur_floor);
        end
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL hold_cycle%0d: door_open got %b want 1", i, door_open); end
        end
        door_hold = 1'b0;
        repeat (2) tick();
        n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL hold_release_dwell: door_open got %b want 1", door_open); end
        tick();
        n_vec++; if (door_open !== 1'b0) begin n_err++; $display("FAIL hold_release_close: door_open got %b want 0", door_open); end
        pulse_call(4'b0100);
        tick();
        n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL hold_reopen: door_open got %b want 1", door_open); end
        door_hold  = 1'b1;
        door_close = 1'b1;
        tick();
        n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL hold_beats_close: door_open got %b want 1", door_open); end
        door_hold = 1'b0;
        tick();
        door_close = 1'b0;
        n_vec++; if (door_open !== 1'b0) begin n_err++; $display("FAIL close_pulse: door_open got %b want 0", door_open); end
    endtask

    task automatic test_reset_mid_move();
        bit ok;
        do_reset();
        pulse_call(4'b1000);
        wait_floor(2'd1, ok);
        repeat (2) tick();
        n_vec++; if (!ok || moving !== 1'b1) begin
            n_err++; $display("FAIL midmove_pre: reached %b moving %b want 1", ok, moving);
        end
        reset    = 1'b1;
        call_req = 4'b1111;
        tick();
        n_vec++; if (cur_floor !== 2'd0 || moving !== 1'b0 || pending !== 4'b0000 || door_open !== 1'b0 || dir_up !== 1'b1) begin
            n_err++;
            $display("FAIL midmove_reset: floor %0d moving %b pending %b door %b dir %b, want 0 0 0000 0 1",
                     cur_floor, moving, pending, door_open, dir_up);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_enable_freeze();
        do_reset();
        pulse_call(4'b0001);
        tick();
        n_vec++; if (door_open !== 1'b1 || cur_floor !== 2'd0) begin
            n_err++; $display("FAIL freeze_open: door %b floor %0d want 1 0", door_open, cur_floor);
        end
        enable = 1'b0;
        pulse_call(4'b0010);
        repeat (19) tick();
        n_vec++; if (door_open !== 1'b1 || pending !== 4'b0010) begin
            n_err++; $display("FAIL freeze_hold: door %b pending %b want 1 0010", door_open, pending);
        end
        enable = 1'b1;
        repeat (2) tick();
        n_vec++; if (door_open !== 1'b1) begin n_err++; $display("FAIL freeze_resume_dwell: door_open got %b want 1", door_open); end
        tick();
        n_vec++; if (door_open !== 1'b0 || moving !== 1'b1) begin
            n_err++; $display("FAIL freeze_resume_close: door %b moving %b want 0 1", door_open, moving);
        end
    endtask

    task automatic test_random();
        logic [FW-1:0] exp_floor;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 599) == 0);
            enable     = ($urandom_range(0, 7) != 0);
            door_hold  = ($urandom_range(0, 9) == 0);
            door_close = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < FLOORS; b++) call_req[b] = ($urandom_range(0, 15) == 0);
            tick();
            exp_floor = m_floor[FW-1:0];
            n_vec++;
            if (cur_floor !== exp_floor || dir_up !== m_up || moving !== (m_mode == M_TRAVEL) ||
                door_open !== (m_mode == M_DWELL) || pending !== m_req) begin
                n_err++;
                $display("FAIL random_cycle%0d: got floor %0d dir %b mov %b door %b pend %b, want %0d %b %b %b %b",
                         c, cur_floor, dir_up, moving, door_open, pending,
                         exp_floor, m_up, (m_mode == M_TRAVEL), (m_mode == M_DWELL), m_req);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_call();
        test_sweep();
        test_door_hold();
        test_reset_mid_move();
        test_enable_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
